fft_result_streamer: RTL and testbench
======================================

Name: fft_result_streamer

Overview:
- Drain end of the 8-point FFT/IFFT butterfly pipeline.
- Captures one complete 8-point complex frame from the final butterfly stage in the cycle its ready strobe is sampled high.
- Replays the frame one complex sample per beat over a valid/ready stream toward the RISC-V core's load/store path.
- Frames that arrive while a drain is in progress are dropped and counted; the pipeline itself has no back-pressure.

Parameters:
- DATA_W, 32, width of each real/imag word (matches the codebase `instWidth).
- BITREV, 0, 0: beat k carries slot k+1; 1: beat k carries slot bitrev3(k)+1.
- CNT_W, 8, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- frame_ready_i  in  1  final-stage ready strobe (butterfly-stage ready output); may stay high for many cycles.
- fft_dK_real_i  in  DATA_W  real part of slot K, K=1..8 (8 ports), signed.
- fft_dK_imag_i  in  DATA_W  imag part of slot K, K=1..8 (8 ports), signed.
- out_valid_o  out  1  stream beat valid.
- out_ready_i  in  1  consumer accepts beat.
- out_real_o  out  DATA_W  beat real part.
- out_imag_o  out  DATA_W  beat imag part.
- out_index_o  out  3  beat number 0..7 within the frame.
- out_last_o  out  1  high with beat 7.
- busy_o  out  1  high while a frame is held (state DRAIN).
- ovf_o  out  1  sticky: at least one frame was dropped.
- drop_cnt_o  out  CNT_W  saturating count of dropped frames.
- ovf_clr_i  in  1  clears ovf_o and drop_cnt_o.

Behaviour:
- Reset (rst high at posedge): state IDLE, out_valid_o=0, out_real_o=0, out_imag_o=0, out_index_o=0, out_last_o=0, busy_o=0, ovf_o=0, drop_cnt_o=0. Capture buffer contents are don't-care.
- rst wins over every other input, including mid-drain: the held frame is discarded and the stream restarts clean.
- States:
  - IDLE: out_valid_o=0. frame_ready_i=1 → latch all 16 words into the buffer, idx=0, go to DRAIN. Latency: out_valid_o is high the cycle after capture.
  - DRAIN: out_valid_o=1. out_real_o/out_imag_o are taken from the buffer slot selected by idx (per BITREV). out_index_o=idx; out_last_o=(idx==7).
- Handshake: a beat transfers when out_valid_o and out_ready_i are both high at posedge.
  - Outputs hold stable while out_ready_i is low.
  - out_valid_o never drops before the transfer completes.
- On a transfer with idx<7: idx increments and the next beat is presented the next cycle, so a frame drains in 8 cycles at full rate.
- Last-beat transfer (idx=7):
  - If frame_ready_i=1 in the same cycle: capture the new frame, idx=0, stay in DRAIN (back-to-back, no bubble).
  - Otherwise: go to IDLE.
- Drop: frame_ready_i=1 while in DRAIN and not on the last-beat transfer cycle. The input is ignored, ovf_o is set, and drop_cnt_o increments, saturating at 2^CNT_W-1.
  - Because frame_ready_i is level, each high cycle counts as one frame. A strobe held high through a drain therefore counts once per cycle.
- ovf_clr_i=1: ovf_o=0 and drop_cnt_o=0 next cycle. If a drop occurs in the same cycle, the clear wins for that cycle's drop (counter reads 0).
- Data passes bit-exact: no scaling, rounding or sign handling beyond a straight copy.
- BITREV=1 order is slots 1,5,3,7,2,6,4,8 for beats 0..7.

Test Plan:
- Single frame, BITREV=0, out_ready_i=1: slot K real=K, imag=-K, frame_ready_i pulsed 1 cycle → beats real 1..8 / imag -1..-8 on 8 consecutive cycles starting 1 cycle after the pulse; out_last_o only on beat 7; busy_o low after.
- Back-pressure: out_ready_i toggles 1,0,0,1,... → each beat is held unchanged while ready is low; exactly 8 transfers; no data loss or repeat.
- Back-to-back: frame B strobed in the cycle frame A's beat 7 transfers → beat 0 of B appears the next cycle; out_valid_o never deasserts; drop_cnt_o=0.
- Overflow: frame_ready_i held high 5 cycles during a drain with out_ready_i=0 → ovf_o=1, drop_cnt_o=5; then ovf_clr_i pulse → both 0; CNT_W=3 with 10 drops → saturates at 7.
- BITREV=1 with slot values 10..80 → beat order 10,50,30,70,20,60,40,80.
- Reset mid-drain after beat 3 → next cycle out_valid_o=0 and busy_o=0; a following frame drains from beat 0 with its own data.

Source files
------------

// File: rtl/fft_result_streamer.sv
// Captures one 8-point complex FFT frame and replays it one sample per beat (first beat valid 1 cycle after capture).
// Beats hold under out_ready_i low; frames strobed mid-drain are dropped and counted, last-beat strobes chain without a bubble.
module fft_result_streamer #(
  parameter int DATA_W = 32,
  parameter int BITREV = 0,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_ready_i,
  input  logic signed [DATA_W-1:0] fft_d1_real_i,
  input  logic signed [DATA_W-1:0] fft_d1_imag_i,
  input  logic signed [DATA_W-1:0] fft_d2_real_i,
  input  logic signed [DATA_W-1:0] fft_d2_imag_i,
  input  logic signed [DATA_W-1:0] fft_d3_real_i,
  input  logic signed [DATA_W-1:0] fft_d3_imag_i,
  input  logic signed [DATA_W-1:0] fft_d4_real_i,
  input  logic signed [DATA_W-1:0] fft_d4_imag_i,
  input  logic signed [DATA_W-1:0] fft_d5_real_i,
  input  logic signed [DATA_W-1:0] fft_d5_imag_i,
  input  logic signed [DATA_W-1:0] fft_d6_real_i,
  input  logic signed [DATA_W-1:0] fft_d6_imag_i,
  input  logic signed [DATA_W-1:0] fft_d7_real_i,
  input  logic signed [DATA_W-1:0] fft_d7_imag_i,
  input  logic signed [DATA_W-1:0] fft_d8_real_i,
  input  logic signed [DATA_W-1:0] fft_d8_imag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [DATA_W-1:0] out_real_o,
  output logic signed [DATA_W-1:0] out_imag_o,
  output logic [2:0]               out_index_o,
  output logic                     out_last_o,
  output logic                     busy_o,
  output logic                     ovf_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  input  logic                     ovf_clr_i
);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  cplx_t      in_slot   [8];
  cplx_t      frame_buf [8];
  logic       xfer;
  logic       last_xfer;
  logic       capture;
  logic       drop;
  logic [2:0] nxt_idx;

  assign in_slot[0] = cplx_t'{re: fft_d1_real_i, im: fft_d1_imag_i};
  assign in_slot[1] = cplx_t'{re: fft_d2_real_i, im: fft_d2_imag_i};
  assign in_slot[2] = cplx_t'{re: fft_d3_real_i, im: fft_d3_imag_i};
  assign in_slot[3] = cplx_t'{re: fft_d4_real_i, im: fft_d4_imag_i};
  assign in_slot[4] = cplx_t'{re: fft_d5_real_i, im: fft_d5_imag_i};
  assign in_slot[5] = cplx_t'{re: fft_d6_real_i, im: fft_d6_imag_i};
  assign in_slot[6] = cplx_t'{re: fft_d7_real_i, im: fft_d7_imag_i};
  assign in_slot[7] = cplx_t'{re: fft_d8_real_i, im: fft_d8_imag_i};

  function automatic logic [2:0] slot_of(input logic [2:0] beat);
    return (BITREV != 0) ? {beat[0], beat[1], beat[2]} : beat;
  endfunction

  assign xfer      = out_valid_o & out_ready_i;
  assign last_xfer = xfer & out_last_o;
  assign capture   = frame_ready_i & ((state == IDLE) | last_xfer);
  assign drop      = frame_ready_i & (state == DRAIN) & ~last_xfer;
  assign nxt_idx   = out_index_o + 3'd1;

  // Outputs are registered: each branch loads the beat that will be presented next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_o <= 1'b0;
      out_real_o  <= '0;
      out_imag_o  <= '0;
      out_index_o <= 3'd0;
      out_last_o  <= 1'b0;
      busy_o      <= 1'b0;
      ovf_o       <= 1'b0;
      drop_cnt_o  <= '0;
    end else begin
      if (capture) begin
        frame_buf   <= in_slot;
        out_real_o  <= in_slot[slot_of(3'd0)].re;
        out_imag_o  <= in_slot[slot_of(3'd0)].im;
        out_index_o <= 3'd0;
        out_last_o  <= 1'b0;
        out_valid_o <= 1'b1;
        busy_o      <= 1'b1;
        state       <= DRAIN;
      end else if (last_xfer) begin
        out_real_o  <= '0;
        out_imag_o  <= '0;
        out_index_o <= 3'd0;
        out_last_o  <= 1'b0;
        out_valid_o <= 1'b0;
        busy_o      <= 1'b0;
        state       <= IDLE;
      end else if (xfer) begin
        out_real_o  <= frame_buf[slot_of(nxt_idx)].re;
        out_imag_o  <= frame_buf[slot_of(nxt_idx)].im;
        out_index_o <= nxt_idx;
        out_last_o  <= (nxt_idx == 3'd7);
      end

      // A clear in the same cycle as a drop discards that drop.
      if (ovf_clr_i) begin
        ovf_o      <= 1'b0;
        drop_cnt_o <= '0;
      end else if (drop) begin
        ovf_o <= 1'b1;
        if (drop_cnt_o != CNT_MAX) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Scoreboard bench: a natural-order instance and a bit-reversed, 3-bit-counter instance share all stimulus.
module tb_fft_result_streamer;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        frame_ready;
  logic        out_ready;
  logic        ovf_clr;
  logic [31:0] re_d [8];
  logic [31:0] im_d [8];

  logic        v0, l0, b0, o0;
  logic [31:0] r0, i0;
  logic [2:0]  x0;
  logic [7:0]  c0;
  logic        v1, l1, b1, o1;
  logic [31:0] r1, i1;
  logic [2:0]  x1;
  logic [2:0]  c1;

  beat_t q0[$];
  beat_t q1[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  bit    rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  fft_result_streamer #(.DATA_W(32), .BITREV(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .frame_ready_i(frame_ready),
    .fft_d1_real_i(re_d[0]), .fft_d1_imag_i(im_d[0]),
    .fft_d2_real_i(re_d[1]), .fft_d2_imag_i(im_d[1]),
    .fft_d3_real_i(re_d[2]), .fft_d3_imag_i(im_d[2]),
    .fft_d4_real_i(re_d[3]), .fft_d4_imag_i(im_d[3]),
    .fft_d5_real_i(re_d[4]), .fft_d5_imag_i(im_d[4]),
    .fft_d6_real_i(re_d[5]), .fft_d6_imag_i(im_d[5]),
    .fft_d7_real_i(re_d[6]), .fft_d7_imag_i(im_d[6]),
    .fft_d8_real_i(re_d[7]), .fft_d8_imag_i(im_d[7]),
    .out_valid_o(v0), .out_ready_i(out_ready),
    .out_real_o(r0), .out_imag_o(i0), .out_index_o(x0), .out_last_o(l0),
    .busy_o(b0), .ovf_o(o0), .drop_cnt_o(c0), .ovf_clr_i(ovf_clr)
  );

  fft_result_streamer #(.DATA_W(32), .BITREV(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .frame_ready_i(frame_ready),
    .fft_d1_real_i(re_d[0]), .fft_d1_imag_i(im_d[0]),
    .fft_d2_real_i(re_d[1]), .fft_d2_imag_i(im_d[1]),
    .fft_d3_real_i(re_d[2]), .fft_d3_imag_i(im_d[2]),
    .fft_d4_real_i(re_d[3]), .fft_d4_imag_i(im_d[3]),
    .fft_d5_real_i(re_d[4]), .fft_d5_imag_i(im_d[4]),
    .fft_d6_real_i(re_d[5]), .fft_d6_imag_i(im_d[5]),
    .fft_d7_real_i(re_d[6]), .fft_d7_imag_i(im_d[6]),
    .fft_d8_real_i(re_d[7]), .fft_d8_imag_i(im_d[7]),
    .out_valid_o(v1), .out_ready_i(out_ready),
    .out_real_o(r1), .out_imag_o(i1), .out_index_o(x1), .out_last_o(l1),
    .busy_o(b1), .ovf_o(o1), .drop_cnt_o(c1), .ovf_clr_i(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int rb, input int rs, input int ib, input int is);
    for (int k = 0; k < 8; k++) begin
      re_d[k] = 32'(rb + k * rs);
      im_d[k] = 32'(ib + k * is);
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < 8; k++) begin
      q0.push_back(beat_t'{re: re_d[k], im: im_d[k], idx: 3'(k), last: (k == 7)});
      q1.push_back(beat_t'{re: re_d[br_tab[k]], im: im_d[br_tab[k]], idx: 3'(k), last: (k == 7)});
    end
  endtask

  // Strobe one accepted frame; the scoreboard is loaded at the capturing edge.
  task automatic capture();
    frame_ready = 1'b1;
    @(posedge clk);
    push_frame();
    #1 frame_ready = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc, input bit bp);
    for (int c = 0; c < maxc; c++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      out_ready = bp ? rdy_pat[c % 4] : 1'b1;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    chk({tag, "_left0"}, 64'(q0.size()), 64'd0);
    chk({tag, "_left1"}, 64'(q1.size()), 64'd0);
  endtask

  // Beats are compared against the queue head every cycle they are valid, so held beats are rechecked.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid0", 64'(v0), 64'(q0.size() > 0));
      chk("busy0", 64'(b0), 64'(q0.size() > 0));
      if (v0 && q0.size() > 0) begin
        chk("real0", 64'(r0), 64'(q0[0].re));
        chk("imag0", 64'(i0), 64'(q0[0].im));
        chk("index0", 64'(x0), 64'(q0[0].idx));
        chk("last0", 64'(l0), 64'(q0[0].last));
        if (out_ready) void'(q0.pop_front());
      end
      chk("valid1", 64'(v1), 64'(q1.size() > 0));
      if (v1 && q1.size() > 0) begin
        chk("real1", 64'(r1), 64'(q1[0].re));
        chk("imag1", 64'(i1), 64'(q1[0].im));
        chk("index1", 64'(x1), 64'(q1[0].idx));
        chk("last1", 64'(l1), 64'(q1[0].last));
        if (out_ready) void'(q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_ready = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    fill(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_real", 64'(r0), 64'd0);
    chk("rst_imag", 64'(i0), 64'd0);
    chk("rst_index", 64'(x0), 64'd0);
    chk("rst_last", 64'(l0), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);
    chk("rst_ovf", 64'(o0), 64'd0);
    chk("rst_cnt", 64'(c0), 64'd0);
    chk("rst_cnt1", 64'(c1), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single frame at full rate; inputs change after capture to prove the buffer latched.
    out_ready = 1'b1;
    fill(1, 1, -1, -1);
    capture();
    fill(777, 3, 555, 3);
    drain("single", 20, 1'b0);
    @(negedge clk);
    chk("single_busy", 64'(b0), 64'd0);

    // Back-pressure 1,0,0,1...
    @(posedge clk); #1;
    fill(100, 1, -100, -1);
    capture();
    drain("bp", 60, 1'b1);

    // Back-to-back: frame B strobed in the cycle of A's last-beat transfer.
    @(posedge clk); #1;
    fill(200, 1, -200, -1);
    capture();
    repeat (7) @(posedge clk);
    #1;
    fill(300, 2, -300, -2);
    capture();
    drain("b2b", 20, 1'b0);
    @(negedge clk);
    chk("b2b_cnt", 64'(c0), 64'd0);
    chk("b2b_ovf", 64'(o0), 64'd0);

    // Overflow: ready low, strobe held high through the drain.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fill(400, 1, -400, -1);
    capture();
    frame_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 frame_ready = 1'b0;
    @(negedge clk);
    chk("ovf_set", 64'(o0), 64'd1);
    chk("drop5", 64'(c0), 64'd5);
    chk("drop5_c3", 64'(c1), 64'd5);
    frame_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 frame_ready = 1'b0;
    @(negedge clk);
    chk("drop10", 64'(c0), 64'd10);
    chk("drop_sat_c3", 64'(c1), 64'd7);
    chk("ovf_set_c3", 64'(o1), 64'd1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("clr_ovf", 64'(o0), 64'd0);
    chk("clr_cnt", 64'(c0), 64'd0);
    chk("clr_cnt_c3", 64'(c1), 64'd0);
    ovf_clr = 1'b1;
    frame_ready = 1'b1;
    @(posedge clk);
    #1 begin ovf_clr = 1'b0; frame_ready = 1'b0; end
    @(negedge clk);
    chk("clr_wins_cnt", 64'(c0), 64'd0);
    chk("clr_wins_ovf", 64'(o0), 64'd0);
    drain("ovf", 20, 1'b0);

    // Bit-reversed order on dut1: 10,50,30,70,20,60,40,80.
    @(posedge clk); #1;
    fill(10, 10, -10, -10);
    capture();
    drain("brev", 20, 1'b0);

    // Reset after beat 3 of a frame, then a fresh frame.
    @(posedge clk); #1;
    fill(500, 1, -500, -1);
    capture();
    repeat (4) @(posedge clk);
    #1 begin rst = 1'b1; out_ready = 1'b0; end
    @(posedge clk);
    q0.delete();
    q1.delete();
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", 64'(v0), 64'd0);
    chk("rstmid_busy", 64'(b0), 64'd0);
    chk("rstmid_valid1", 64'(v1), 64'd0);
    out_ready = 1'b1;
    fill(600, 5, -600, -5);
    capture();
    drain("post_rst", 20, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
